// File: rtl/dds_pkg.sv
// Shared types for the DDS front-end: modulation modes,
// debounce FSM states and 40 MHz debounce defaults.
package dds_pkg;

  localparam int DEBOUNCE_CYC_40M = 800000;
  localparam int CNT_W_40M        = 20;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_ASK  = 2'd1,
    MODE_FSK  = 2'd2,
    MODE_PSK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    DB_RELEASED     = 2'd0,
    DB_PRESS_WAIT   = 2'd1,
    DB_PRESSED      = 2'd2,
    DB_RELEASE_WAIT = 2'd3
  } db_state_e;

  // Lowest key index wins when presses coincide.
  function automatic mode_e key_to_mode(
    input logic [2:0] p
  );
    mode_e m;
    m = MODE_IDLE;
    priority case (1'b1)
      p[0]:    m = MODE_ASK;
      p[1]:    m = MODE_FSK;
      p[2]:    m = MODE_PSK;
      default: m = MODE_IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low button: two-flop synchroniser,
// four-state debounce FSM and a one-cycle press pulse.
module key_debounce
  import dds_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_40M,
  parameter int CNT_W        = CNT_W_40M
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q, sync_d;
  logic             key_s;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             cnt_done;

  assign sync_d   = {sync_q[0], key_n};
  assign key_s    = sync_q[1];
  assign cnt_done = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= DB_RELEASED;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // The counter only runs in the wait states and is
  // cleared on every entry, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DB_RELEASED: begin
        if (!key_s) begin
          state_d = DB_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      DB_PRESS_WAIT: begin
        if (key_s) begin
          state_d = DB_RELEASED;
        end else if (cnt_done) begin
          state_d = DB_PRESSED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DB_PRESSED: begin
        if (key_s) begin
          state_d = DB_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      DB_RELEASE_WAIT: begin
        if (!key_s) begin
          state_d = DB_PRESSED;
        end else if (cnt_done) begin
          state_d = DB_RELEASED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = DB_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pulse_d = 1'b0;
    if (state_q == DB_PRESS_WAIT &&
        !key_s && cnt_done) begin
      pulse_d = 1'b1;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/key_mode_ctrl.sv
// Button front-end: three debouncers, priority pick
// and the registered modulation mode with change strobe.
module key_mode_ctrl
  import dds_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_40M,
  parameter int CNT_W        = CNT_W_40M
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key,
  output logic [2:0] key_pulse,
  output logic [1:0] mode,
  output logic       mode_chg
);

  logic [2:0] pulse_w;
  mode_e      mode_q, mode_d;
  mode_e      sel;
  logic       chg_q, chg_d;

  for (genvar i = 0; i < 3; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W)
    ) u_db (
      .clk   (clk),
      .rst_n (rst),
      .key_n (key[i]),
      .pulse (pulse_w[i])
    );
  end

  assign sel = key_to_mode(pulse_w);

  always_comb begin
    mode_d = mode_q;
    chg_d  = 1'b0;
    if (|pulse_w) begin
      mode_d = sel;
      chg_d  = (sel != mode_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_IDLE;
      chg_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      chg_q  <= chg_d;
    end
  end

  assign key_pulse = pulse_w;
  assign mode      = mode_q;
  assign mode_chg  = chg_q;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Scoreboard bench for key_mode_ctrl with a short
// debounce window; monitor checks pulses and mode strobes.
module tb_key_mode_ctrl;

  localparam int N   = 16;
  localparam int LAT = N + 2;

  logic       clk;
  logic       rst;
  logic [2:0] key;
  logic [2:0] key_pulse;
  logic [1:0] mode;
  logic       mode_chg;

  key_mode_ctrl #(
    .DEBOUNCE_CYC (N),
    .CNT_W        (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .key_pulse (key_pulse),
    .mode      (mode),
    .mode_chg  (mode_chg)
  );

  typedef struct {
    int         cyc;
    logic [2:0] val;
  } pexp_t;

  typedef struct {
    int         cyc;
    logic [1:0] val;
  } mexp_t;

  pexp_t pq[$];
  mexp_t mq[$];

  int   cyc;
  int   tests;
  int   fails;
  logic [1:0] mode_prev;

  initial clk = 1'b0;
  always #12.5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input int act,
                       input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (key_pulse !== 3'b000) begin
      if (pq.size() == 0) begin
        check("unexpected key_pulse",
              int'(key_pulse), 0);
      end else begin
        pexp_t e;
        e = pq.pop_front();
        check("key_pulse value",
              int'(key_pulse), int'(e.val));
        check("key_pulse cycle", cyc, e.cyc);
      end
    end
    if (mode_chg === 1'b1) begin
      if (mq.size() == 0) begin
        check("unexpected mode_chg", 1, 0);
      end else begin
        mexp_t e;
        e = mq.pop_front();
        check("mode value", int'(mode), int'(e.val));
        check("mode_chg cycle", cyc, e.cyc);
      end
    end else if (rst === 1'b1 &&
                 mode !== mode_prev) begin
      check("mode moved without mode_chg",
            int'(mode), int'(mode_prev));
    end
    mode_prev = mode;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_press(input logic [2:0] p,
                              input logic       chg,
                              input logic [1:0] m);
    pexp_t pe;
    mexp_t me;
    pe.cyc = cyc + 1 + LAT;
    pe.val = p;
    pq.push_back(pe);
    if (chg) begin
      me.cyc = cyc + 2 + LAT;
      me.val = m;
      mq.push_back(me);
    end
  endtask

  task automatic press(input logic [2:0] k,
                       input logic [2:0] p,
                       input logic       chg,
                       input logic [1:0] m);
    key = k;
    expect_press(p, chg, m);
  endtask

  task automatic release_all();
    key = 3'b111;
    wait_cyc(LAT + 8);
  endtask

  initial begin
    cyc       = 0;
    tests     = 0;
    fails     = 0;
    mode_prev = 2'd0;
    key       = 3'b111;
    rst       = 1'b0;
    #100;
    check("reset key_pulse", int'(key_pulse), 0);
    check("reset mode", int'(mode), 0);
    check("reset mode_chg", int'(mode_chg), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      check("idle outputs",
            int'({key_pulse, mode, mode_chg}), 0);
    end

    press(3'b011, 3'b100, 1'b1, 2'd3);
    wait_cyc(400);
    check("mode after PSK", int'(mode), 3);

    press(3'b101, 3'b010, 1'b1, 2'd2);
    wait_cyc(400);
    check("mode after FSK", int'(mode), 2);

    press(3'b110, 3'b001, 1'b1, 2'd1);
    wait_cyc(400);
    check("mode after ASK", int'(mode), 1);
    release_all();

    for (int i = 0; i < 20; i++) begin
      key = (i % 2 == 0) ? 3'b110 : 3'b111;
      wait_cyc(5);
    end
    key = 3'b111;
    wait_cyc(LAT + 8);
    check("mode after bounce", int'(mode), 1);

    press(3'b100, 3'b011, 1'b0, 2'd1);
    wait_cyc(LAT + 8);
    check("mode after dual press", int'(mode), 1);
    release_all();

    key = 3'b011;
    wait_cyc(10);
    rst = 1'b0;
    #1;
    check("mid reset key_pulse", int'(key_pulse), 0);
    check("mid reset mode", int'(mode), 0);
    check("mid reset mode_chg", int'(mode_chg), 0);
    wait_cyc(3);
    rst = 1'b1;
    expect_press(3'b100, 1'b1, 2'd3);
    wait_cyc(LAT + 8);
    check("mode after reset press", int'(mode), 3);
    release_all();

    press(3'b011, 3'b100, 1'b0, 2'd3);
    wait_cyc(LAT + 8);
    check("mode after re-press", int'(mode), 3);
    release_all();

    check("missing key_pulse events", pq.size(), 0);
    check("missing mode_chg events", mq.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
